// File: rtl/rst_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rst_ctrl_pkg
//  Description : Shared types and constants for the board reset sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package rst_ctrl_pkg;

    // Width of the sticky reset-cause record and the position of each cause.
    localparam int c_CAUSE_WIDTH   = 4;
    localparam int c_CAUSE_BIT_POR = 0;
    localparam int c_CAUSE_BIT_BTN = 1;
    localparam int c_CAUSE_BIT_PLL = 2;
    localparam int c_CAUSE_BIT_SW  = 3;

    // Cause value after a power-on/configuration reset.
    localparam logic [c_CAUSE_WIDTH-1:0] c_CAUSE_POR_ONLY = 4'b0001;

    // Width of the hold and debounce counters (parameters go up to 65535).
    localparam int c_CNT_WIDTH = 16;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_HOLD      = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_RUN       = 2'd2
    } state_e;

endpackage : rst_ctrl_pkg
`default_nettype wire

// File: rtl/rst_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : rst_debounce
//  Description : Synchronises the raw reset button and debounces it; the
//                output level only follows the button after it has been seen
//                stable at the new level for DEBOUNCE_CYCLES samples.
//  Revision    : 1.0 - initial release
// ============================================================================
module rst_debounce
    import rst_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_rst_ni,
    output logic btn_level_o
);

    localparam logic [c_CNT_WIDTH-1:0] c_DB_LAST = c_CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                   r_btn_sync1;
    logic                   r_btn_sync2;
    logic                   r_btn_level;
    logic [c_CNT_WIDTH-1:0] r_db_cnt;

    // Two-flop synchroniser; resets to 1 so the button reads as released.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_btn_sync1 <= 1'b1;
            r_btn_sync2 <= 1'b1;
        end else begin
            r_btn_sync1 <= btn_rst_ni;
            r_btn_sync2 <= r_btn_sync1;
        end
    end

    // Count consecutive samples that disagree with the accepted level; flip on the last one.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_btn_level <= 1'b1;
            r_db_cnt    <= '0;
        end else if (r_btn_sync2 != r_btn_level) begin
            if (r_db_cnt == c_DB_LAST) begin
                r_btn_level <= r_btn_sync2;
                r_db_cnt    <= '0;
            end else begin
                r_db_cnt    <= r_db_cnt + 1'b1;
            end
        end else begin
            r_db_cnt <= '0;
        end
    end

    assign btn_level_o = r_btn_level;

endmodule : rst_debounce
`default_nettype wire

// File: rtl/rst_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rst_ctrl
//  Description : Board-level reset sequencer. Merges power-on reset, a
//                debounced reset button, PLL lock and software requests into
//                one registered active-low reset with a minimum hold time,
//                and keeps a sticky record of what caused the last reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module rst_ctrl
    import rst_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned HOLD_CYCLES     = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     btn_rst_ni,
    input  logic                     pll_locked_i,
    input  logic                     sw_rst_req_i,
    input  logic                     cause_clr_i,
    output logic                     rst_no,
    output logic [c_CAUSE_WIDTH-1:0] rst_cause_o
);

    localparam logic [c_CNT_WIDTH-1:0] c_HOLD_LAST = c_CNT_WIDTH'(HOLD_CYCLES - 1);

    logic                     r_pll_sync1;
    logic                     r_pll_sync2;
    logic                     w_btn_level;
    logic                     w_btn_pressed;
    state_e                   r_state;
    state_e                   w_state_next;
    logic [c_CNT_WIDTH-1:0]   r_hold_cnt;
    logic [c_CNT_WIDTH-1:0]   w_hold_cnt_next;
    logic                     r_rst_n;
    logic [c_CAUSE_WIDTH-1:0] r_cause;
    logic [c_CAUSE_WIDTH-1:0] w_cause_next;
    logic [c_CAUSE_WIDTH-1:0] w_trig;

    rst_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .btn_rst_ni  (btn_rst_ni),
        .btn_level_o (w_btn_level)
    );

    assign w_btn_pressed = ~w_btn_level;

    // Two-flop synchroniser for the asynchronous PLL lock indicator.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pll_sync1 <= 1'b0;
            r_pll_sync2 <= 1'b0;
        end else begin
            r_pll_sync1 <= pll_locked_i;
            r_pll_sync2 <= r_pll_sync1;
        end
    end

    // Sequencer state, hold counter, cause record and the registered reset output.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= ST_HOLD;
            r_hold_cnt <= '0;
            r_rst_n    <= 1'b0;
            r_cause    <= c_CAUSE_POR_ONLY;
        end else begin
            r_state    <= w_state_next;
            r_hold_cnt <= w_hold_cnt_next;
            r_rst_n    <= (w_state_next == ST_RUN);
            r_cause    <= w_cause_next;
        end
    end

    // Next-state, hold counting and cause capture; software inputs only matter in Run.
    always_comb begin
        w_state_next    = r_state;
        w_hold_cnt_next = '0;
        w_cause_next    = r_cause;
        w_trig          = '0;
        case (r_state)
            ST_HOLD: begin
                if (w_btn_pressed) begin
                    w_hold_cnt_next = '0;
                end else if (r_hold_cnt == c_HOLD_LAST) begin
                    w_state_next    = ST_WAIT_LOCK;
                end else begin
                    w_hold_cnt_next = r_hold_cnt + 1'b1;
                end
            end
            ST_WAIT_LOCK: begin
                if (w_btn_pressed) begin
                    w_state_next = ST_HOLD;
                end else if (r_pll_sync2) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                w_trig[c_CAUSE_BIT_BTN] = w_btn_pressed;
                w_trig[c_CAUSE_BIT_PLL] = ~r_pll_sync2;
                w_trig[c_CAUSE_BIT_SW]  = sw_rst_req_i;
                if (|w_trig) begin
                    w_state_next = ST_HOLD;
                end
                // A clear in the same cycle as a new cause keeps only the new bits.
                w_cause_next = (cause_clr_i ? '0 : r_cause) | w_trig;
            end
            default: begin
                w_state_next = ST_HOLD;
            end
        endcase
    end

    assign rst_no      = r_rst_n;
    assign rst_cause_o = r_cause;

endmodule : rst_ctrl
`default_nettype wire

// File: tb/tb_rst_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rst_ctrl
//  Description : Randomised scoreboard bench for the board reset sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rst_ctrl;
    import rst_ctrl_pkg::*;

    localparam int DEB  = 4;
    localparam int HOLD = 8;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       btn_rst_ni = 1'b1;
    logic       pll_locked_i = 1'b1;
    logic       sw_rst_req_i = 1'b0;
    logic       cause_clr_i = 1'b0;
    logic       rst_no;
    logic [3:0] rst_cause_o;

    always #5 clk = ~clk;

    rst_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_CYCLES     (HOLD)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .btn_rst_ni   (btn_rst_ni),
        .pll_locked_i (pll_locked_i),
        .sw_rst_req_i (sw_rst_req_i),
        .cause_clr_i  (cause_clr_i),
        .rst_no       (rst_no),
        .rst_cause_o  (rst_cause_o)
    );

    typedef struct packed {
        logic       rst_n;
        logic [3:0] cause;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model: inputs seen through a two-sample delay line, a streak
    // count of disagreeing button samples, a "quiet cycles" count for the hold,
    // and a mode number (0 holding, 1 waiting for lock, 2 running).
    bit       m_btn_pipe[$];
    bit       m_pll_pipe[$];
    bit       m_level;
    int       m_streak;
    int       m_mode;
    int       m_quiet;
    bit [3:0] m_cause;

    task automatic model_reset();
        m_btn_pipe.delete();
        m_btn_pipe.push_back(1'b1);
        m_btn_pipe.push_back(1'b1);
        m_pll_pipe.delete();
        m_pll_pipe.push_back(1'b0);
        m_pll_pipe.push_back(1'b0);
        m_level  = 1'b1;
        m_streak = 0;
        m_mode   = 0;
        m_quiet  = 0;
        m_cause  = 4'b0001;
    endtask

    task automatic model_step(input bit btn, input bit pll, input bit sw, input bit clr);
        bit       pressed;
        bit       locked;
        bit       seen;
        bit [3:0] trig;
        pressed = !m_level;
        locked  = m_pll_pipe[0];
        seen    = m_btn_pipe[0];
        case (m_mode)
            0: begin
                if (pressed) m_quiet = 0;
                else begin
                    m_quiet++;
                    if (m_quiet == HOLD) begin
                        m_mode  = 1;
                        m_quiet = 0;
                    end
                end
            end
            1: begin
                if (pressed) begin
                    m_mode  = 0;
                    m_quiet = 0;
                end else if (locked) m_mode = 2;
            end
            default: begin
                trig = {sw, !locked, pressed, 1'b0};
                if (trig != 4'b0) begin
                    m_cause = (clr ? 4'b0 : m_cause) | trig;
                    m_mode  = 0;
                    m_quiet = 0;
                end else if (clr) m_cause = 4'b0;
            end
        endcase
        if (seen != m_level) begin
            m_streak++;
            if (m_streak == DEB) begin
                m_level  = seen;
                m_streak = 0;
            end
        end else m_streak = 0;
        m_btn_pipe.push_back(btn);
        void'(m_btn_pipe.pop_front());
        m_pll_pipe.push_back(pll);
        void'(m_pll_pipe.pop_front());
    endtask

    // Model advances on every DUT event and queues the expected outputs.
    always @(posedge clk or posedge rst_i) begin
        if (rst_i) model_reset();
        else model_step(btn_rst_ni, pll_locked_i, sw_rst_req_i, cause_clr_i);
        exp_q.push_back('{rst_n: (m_mode == 2), cause: m_cause});
    end

    // Monitor: after each DUT event, pop the expectation and compare.
    exp_t mon_e;
    always @(posedge clk or posedge rst_i) begin
        #1;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard_empty at %0t: no expectation queued", $time);
        end else begin
            mon_e = exp_q.pop_front();
            vectors++;
            if (rst_no !== mon_e.rst_n || rst_cause_o !== mon_e.cause) begin
                miscompares++;
                $display("FAIL outputs at %0t: got rst_no=%b cause=%b, expected rst_no=%b cause=%b",
                         $time, rst_no, rst_cause_o, mon_e.rst_n, mon_e.cause);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_sw();
        sw_rst_req_i = 1'b1;
        @(negedge clk);
        sw_rst_req_i = 1'b0;
    endtask

    int btn_left;
    int pll_left;

    initial begin
        // Power-on with lock present throughout.
        cycles(3);
        rst_i = 1'b0;
        cycles(30);

        // Power-on with lock arriving late.
        rst_i = 1'b1;
        pll_locked_i = 1'b0;
        cycles(2);
        rst_i = 1'b0;
        cycles(20);
        pll_locked_i = 1'b1;
        cycles(10);

        // Clear causes, then a software reset.
        cause_clr_i = 1'b1;
        @(negedge clk);
        cause_clr_i = 1'b0;
        pulse_sw();
        cycles(15);

        // Glitch shorter than the debounce, then a real press.
        btn_rst_ni = 1'b0;
        cycles(3);
        btn_rst_ni = 1'b1;
        cycles(8);
        btn_rst_ni = 1'b0;
        cycles(10);
        btn_rst_ni = 1'b1;
        cycles(25);

        // Lock loss and software request land in the same cycle.
        pll_locked_i = 1'b0;
        cycles(2);
        pulse_sw();
        pll_locked_i = 1'b1;
        cycles(25);

        // Software reset, then power-on reset mid-hold.
        pulse_sw();
        cycles(5);
        rst_i = 1'b1;
        cycles(2);
        rst_i = 1'b0;
        cycles(25);

        // Randomised traffic.
        btn_left = 0;
        pll_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (btn_left == 0) begin
                if (btn_rst_ni) begin
                    btn_rst_ni = 1'b0;
                    btn_left   = int'($urandom_range(1, 12));
                end else begin
                    btn_rst_ni = 1'b1;
                    btn_left   = int'($urandom_range(5, 80));
                end
            end
            btn_left--;
            if (pll_left == 0) begin
                if (pll_locked_i && ($urandom_range(0, 3) == 0)) begin
                    pll_locked_i = 1'b0;
                    pll_left     = int'($urandom_range(1, 20));
                end else begin
                    pll_locked_i = 1'b1;
                    pll_left     = int'($urandom_range(10, 60));
                end
            end
            pll_left--;
            sw_rst_req_i = ($urandom_range(0, 29) == 0);
            cause_clr_i  = ($urandom_range(0, 14) == 0);
            rst_i        = ($urandom_range(0, 399) == 0);
            @(negedge clk);
        end
        sw_rst_req_i = 1'b0;
        cause_clr_i  = 1'b0;
        rst_i        = 1'b0;
        cycles(3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_rst_ctrl
`default_nettype wire
